shared_reg_arbiter: RTL
=======================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 8, meaning the width of the shared register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port req, input, N bits: request per requester, level, held until granted.
REQ-006 The block SHALL have port wdata, input, N*W bits: requester i data in bits [i*W +: W].
REQ-007 The block SHALL have port gnt, output, N bits: one-hot grant, registered.
REQ-008 The block SHALL have port q, output, W bits: the shared register contents.
REQ-009 The block SHALL have port qb, output, W bits: the bitwise inverse of q, combinational.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after a completed load.
REQ-011 The block SHALL have port done_id, output, $clog2(N) bits: the index of the requester just loaded; valid when done=1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and DONE.
REQ-013 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0.
REQ-014 In IDLE with req!=0, the FSM SHALL select the winner as the first set req bit searching ptr, ptr+1, ... mod N; at the next edge it SHALL enter GRANT with gnt=onehot(winner) and latch the winner index.
REQ-015 In GRANT with req[winner]=1, the next edge SHALL set q<=wdata[winner], done=1, done_id=winner, ptr<=(winner+1) mod N, gnt=0, and state DONE.
REQ-016 In GRANT with req[winner]=0 (abort), the next edge SHALL leave q unchanged, keep done=0, keep ptr unchanged, set gnt=0, and return to IDLE.
REQ-017 In DONE, the next edge SHALL clear done and return to IDLE; req is ignored in DONE.
REQ-018 Latency SHALL be as follows: req sampled at edge k gives gnt high after edge k+1, q and done updated after edge k+2, and the earliest next gnt after edge k+4.
REQ-019 gnt SHALL be one-hot or zero at all times; it is nonzero only in GRANT.
REQ-020 done SHALL be high for exactly one cycle per load; the number of done pulses SHALL equal the number of q updates.
REQ-021 q SHALL change only on the GRANT->DONE transition or on reset.
REQ-022 Changes of wdata outside GRANT SHALL have no effect; the value loaded is the one present at the GRANT->DONE edge.
REQ-023 ptr SHALL wrap from N-1 to 0.
REQ-024 Fairness: with all req held high, the grants SHALL cycle 0,1,...,N-1,0 with no requester skipped.
REQ-025 A req that rises while the FSM is in GRANT or DONE SHALL be considered at the next IDLE arbitration.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL set state=IDLE, gnt=0, q=0, done=0, done_id=0 and ptr=0; qb then reads all ones.
REQ-027 Reset SHALL take priority over all other activity; reset asserted in GRANT or DONE SHALL abort the transaction with no load, and done SHALL be 0 on the following cycle.
REQ-028 On the first edge with reset=0, the block SHALL perform arbitration normally from IDLE using ptr=0.
REQ-029 Outputs SHALL not change asynchronously on reset; reset takes effect only at the clock edge.

Verification
REQ-030 The bench SHALL cover reset with W=8, N=4: assert reset for 2 cycles -> q=0x00, qb=0xFF, gnt=0, done=0.
REQ-031 The bench SHALL cover a single requester: req=4'b0100 held, wdata[2]=0xA5 -> gnt=4'b0100 for 1 cycle, then q=0xA5, qb=0x5A, done=1, done_id=2 for 1 cycle.
REQ-032 The bench SHALL cover round-robin: req=4'b1111 held, wdata[i]=0x10+i -> done_id sequence 0,1,2,3,0 and q values 0x10,0x11,0x12,0x13,0x10, one load every 3 cycles.
REQ-033 The bench SHALL cover abort: req=4'b0010, drop req[1] during GRANT -> q unchanged, no done pulse, ptr still 0; then req=4'b0011 -> grant goes to requester 0.
REQ-034 The bench SHALL cover reset mid-transaction: assert reset in the GRANT cycle with wdata=0xFF -> q=0x00, done never pulses, gnt=0 next cycle.
REQ-035 The bench SHALL cover wrap-around: after a load from requester 3, with req=4'b1001 -> requester 0 is granted before requester 3.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Shared W-bit register written by N round-robin requesters.
// Three-state handshake: arbitrate in IDLE, load in GRANT, report in DONE.
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic [W-1:0]         qb,
  output logic                 done,
  output logic [$clog2(N)-1:0] done_id
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] win, win_n;
  logic [N-1:0]  gnt_n;
  logic [W-1:0]  q_n;
  logic          done_n;
  logic [IW-1:0] done_id_n;

  logic          found;
  logic [IW-1:0] pick;
  int            idx;

  // first set request at or after ptr, wrapping past N-1
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    win_n     = win;
    gnt_n     = '0;
    q_n       = q;
    done_n    = 1'b0;
    done_id_n = done_id;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          win_n   = pick;
          gnt_n   = N'(1) << pick;
        end
      end
      GRANT: begin
        if (req[win]) begin
          state_n   = DONE;
          q_n       = wdata[int'(win)*W +: W];
          done_n    = 1'b1;
          done_id_n = win;
          if (win == IW'(N - 1)) ptr_n = '0;
          else                   ptr_n = win + 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      gnt     <= '0;
      q       <= '0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      win     <= win_n;
      gnt     <= gnt_n;
      q       <= q_n;
      done    <= done_n;
      done_id <= done_id_n;
    end
  end

  assign qb = ~q;

endmodule
